// File: rtl/keypad_pkg.sv
// Shared types, sizes and index helpers for the 4x3 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2
   } state_e;

   localparam int NUM_ROWS       = 4;
   localparam int NUM_COLS       = 3;
   localparam int KEY_CODE_W     = 4;
   localparam int TYPEMATIC_MULT = 32;
   localparam int ROW_IDX_W      = $clog2(NUM_ROWS);
   localparam int COL_IDX_W      = $clog2(NUM_COLS);

   function automatic logic is_onehot(input logic [NUM_ROWS-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   function automatic logic [ROW_IDX_W-1:0] row_index(input logic [NUM_ROWS-1:0] v);
      logic [ROW_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (v[i]) idx = ROW_IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [COL_IDX_W-1:0] col_index(input logic [NUM_COLS-1:0] v);
      logic [COL_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (v[i]) idx = COL_IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [KEY_CODE_W-1:0] key_code_of(input logic [ROW_IDX_W-1:0] r,
                                                          input logic [COL_IDX_W-1:0] c);
      return KEY_CODE_W'(r) * KEY_CODE_W'(NUM_COLS) + KEY_CODE_W'(c);
   endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every CLK_DIV clocks.
module scan_tick_gen #(
   parameter int CLK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] div_cnt_q;
   logic [CNT_W-1:0] div_cnt_d;

   always_comb begin
      tick      = (div_cnt_q == CNT_W'(CLK_DIV - 1));
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) div_cnt_q <= '0;
      else      div_cnt_q <= div_cnt_d;
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad column scanner with per-key debounce; optional auto-repeat
// while held is enabled by defining KEYPAD_TYPEMATIC_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int CLK_DIV        = 1000,
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_ROWS-1:0]   row_in,
   output logic [NUM_COLS-1:0]   col_out,
   output logic [KEY_CODE_W-1:0] key_code,
   output logic                  key_valid,
   output logic                  key_pressed
);

   localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
`ifdef KEYPAD_TYPEMATIC_EN
   localparam int REP_PERIOD = TYPEMATIC_MULT * DEBOUNCE_TICKS;
   localparam int REP_W      = $clog2(REP_PERIOD + 1);
`endif

   logic tick;

   scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   logic [NUM_ROWS-1:0]   sync1_q, sync2_q;
   state_e                state_q, state_d;
   logic [NUM_COLS-1:0]   col_q, col_d;
   logic [NUM_ROWS-1:0]   cap_row_q, cap_row_d;
   logic [COL_IDX_W-1:0]  cap_col_q, cap_col_d;
   logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
   logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
   logic                  key_valid_q, key_valid_d;
   logic                  key_pressed_q, key_pressed_d;
`ifdef KEYPAD_TYPEMATIC_EN
   logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
`endif

   logic [NUM_ROWS-1:0] row;
   logic [DEB_W-1:0]    deb_inc;
   logic [NUM_COLS-1:0] col_next;
   logic                cap_bit;

   always_comb begin
      row      = sync2_q;
      deb_inc  = deb_cnt_q + 1'b1;
      col_next = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
      cap_bit  = |(row & cap_row_q);

      state_d       = state_q;
      col_d         = col_q;
      cap_row_d     = cap_row_q;
      cap_col_d     = cap_col_q;
      deb_cnt_d     = deb_cnt_q;
      key_code_d    = key_code_q;
      key_valid_d   = 1'b0;
      key_pressed_d = key_pressed_q;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_cnt_d     = rep_cnt_q;
`endif

      if (tick) begin
         case (state_q)
            SCAN: begin
               // Idle rows and ghosted multi-row patterns both just move on.
               if (is_onehot(row)) begin
                  cap_row_d = row;
                  cap_col_d = col_index(col_q);
                  deb_cnt_d = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  col_d = col_next;
               end
            end
            DEBOUNCE: begin
               if (row == cap_row_q) begin
                  if (deb_inc >= DEB_W'(DEBOUNCE_TICKS - 1)) begin
                     key_code_d    = key_code_of(row_index(cap_row_q), cap_col_q);
                     key_valid_d   = 1'b1;
                     key_pressed_d = 1'b1;
                     deb_cnt_d     = '0;
                     state_d       = HOLD;
`ifdef KEYPAD_TYPEMATIC_EN
                     rep_cnt_d     = '0;
`endif
                  end else begin
                     deb_cnt_d = deb_inc;
                  end
               end else begin
                  deb_cnt_d = '0;
                  col_d     = col_next;
                  state_d   = SCAN;
               end
            end
            HOLD: begin
               // Only the captured row bit matters here; extra rows are ignored.
               if (!cap_bit) begin
                  if (deb_inc >= DEB_W'(DEBOUNCE_TICKS)) begin
                     key_pressed_d = 1'b0;
                     deb_cnt_d     = '0;
                     col_d         = col_next;
                     state_d       = SCAN;
                  end else begin
                     deb_cnt_d = deb_inc;
                  end
               end else begin
                  deb_cnt_d = '0;
`ifdef KEYPAD_TYPEMATIC_EN
                  if (rep_cnt_q == REP_W'(REP_PERIOD - 1)) begin
                     key_valid_d = 1'b1;
                     rep_cnt_d   = '0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 1'b1;
                  end
`endif
               end
            end
            default: begin
               state_d = SCAN;
               col_d   = {{(NUM_COLS-1){1'b0}}, 1'b1};
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         state_q       <= SCAN;
         col_q         <= {{(NUM_COLS-1){1'b0}}, 1'b1};
         cap_row_q     <= '0;
         cap_col_q     <= '0;
         deb_cnt_q     <= '0;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_pressed_q <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
         rep_cnt_q     <= '0;
`endif
      end else begin
         sync1_q       <= row_in;
         sync2_q       <= sync1_q;
         state_q       <= state_d;
         col_q         <= col_d;
         cap_row_q     <= cap_row_d;
         cap_col_q     <= cap_col_d;
         deb_cnt_q     <= deb_cnt_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_TYPEMATIC_EN
         rep_cnt_q     <= rep_cnt_d;
`endif
      end
   end

   assign col_out     = col_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner driven by a 4x3 keypad matrix model.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] row_in;
   logic [2:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_pressed;
   logic [11:0] keys = '0;

   int n_cmp = 0;
   int n_err = 0;

   int pulse_cnt = 0;
   int dbl_cnt   = 0;
   int cyc       = 0;
   int last_pulse_cyc = 0;
   int prev_pulse_cyc = 0;
   logic [3:0] last_code = '0;
   logic       prev_valid = 1'b0;

   always #5 clk = ~clk;

   keypad_scanner #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .row_in      (row_in),
      .col_out     (col_out),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_pressed (key_pressed)
   );

   // Keypad matrix: a pressed key connects its column strobe to its row line.
   always_comb begin
      row_in = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (keys[r*3+c] && col_out[c]) row_in[r] = 1'b1;
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst && key_valid) begin
         pulse_cnt      <= pulse_cnt + 1;
         last_code      <= key_code;
         prev_pulse_cyc <= last_pulse_cyc;
         last_pulse_cyc <= cyc;
         if (prev_valid) dbl_cnt <= dbl_cnt + 1;
      end
      prev_valid <= key_valid;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   int base;
   logic [2:0] col_snap;

   initial begin
      // Reset and idle rotation
      rst = 1'b0;
      cycles(5);
      check("rst_col", col_out, 3'b001);
      check("rst_code", key_code, 4'd0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_pressed", key_pressed, 1'b0);
      rst = 1'b1;
      cycles(3);
      check("rot_hold", col_out, 3'b001);
      cycles(1);
      check("rot_010", col_out, 3'b010);
      cycles(4);
      check("rot_100", col_out, 3'b100);
      cycles(4);
      check("rot_001", col_out, 3'b001);

      // Clean press of row1/col2 -> code 5
      base = pulse_cnt;
      keys[5] = 1'b1;
      cycles(40);
      check("press_pulses", pulse_cnt - base, 1);
      check("press_code", last_code, 4'd5);
      check("press_held", key_pressed, 1'b1);
      keys[5] = 1'b0;
      cycles(6);
      check("rel_early", key_pressed, 1'b1);
      cycles(14);
      check("rel_done", key_pressed, 1'b0);
      check("rel_code", key_code, 4'd5);
      check("rel_nopulse", pulse_cnt - base, 1);
      col_snap = col_out;
      cycles(4);
      check("rel_scan", (col_out != col_snap), 1'b1);

      // Bounce on row3/col0, then steady -> single code 9
      base = pulse_cnt;
      for (int i = 0; i < 8; i++) begin
         keys[9] = ~keys[9];
         cycles(5);
      end
      check("bounce_none", pulse_cnt - base, 0);
      keys[9] = 1'b1;
      cycles(60);
      check("bounce_pulse", pulse_cnt - base, 1);
      check("bounce_code", last_code, 4'd9);
      keys[9] = 1'b0;
      cycles(30);
      check("bounce_rel", key_pressed, 1'b0);

      // Ghosting: row0/col1 + row2/col1 together, then drop row2 -> code 1
      base = pulse_cnt;
      keys[1] = 1'b1;
      keys[7] = 1'b1;
      cycles(80);
      check("ghost_none", pulse_cnt - base, 0);
      check("ghost_code", key_code, 4'd9);
      keys[7] = 1'b0;
      cycles(40);
      check("ghost_pulse", pulse_cnt - base, 1);
      check("ghost_code1", last_code, 4'd1);
      keys[1] = 1'b0;
      cycles(30);

      // Reset mid-HOLD with row2/col1 held -> code 7 after re-scan
      base = pulse_cnt;
      keys[7] = 1'b1;
      cycles(40);
      check("hold_pressed", key_pressed, 1'b1);
      check("hold_code", key_code, 4'd7);
      rst = 1'b0;
      #1;
      check("mid_rst_col", col_out, 3'b001);
      check("mid_rst_code", key_code, 4'd0);
      check("mid_rst_valid", key_valid, 1'b0);
      check("mid_rst_pressed", key_pressed, 1'b0);
      cycles(5);
      base = pulse_cnt;
      rst = 1'b1;
      cycles(40);
      check("rescan_pulse", pulse_cnt - base, 1);
      check("rescan_code", last_code, 4'd7);
      keys[7] = 1'b0;
      cycles(30);

      // Long hold of key 0 for 300 ticks
      base = pulse_cnt;
      keys[0] = 1'b1;
      cycles(1200);
`ifdef KEYPAD_TYPEMATIC_EN
      check("tm_pulses", pulse_cnt - base, 4);
      check("tm_period", last_pulse_cyc - prev_pulse_cyc, 384);
`else
      check("tm_pulses", pulse_cnt - base, 1);
`endif
      check("tm_code", last_code, 4'd0);
      keys[0] = 1'b0;
      cycles(30);
      check("tm_rel", key_pressed, 1'b0);

      check("no_double_valid", dbl_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
